// File: rtl/effect_chain_sequencer_pkg.sv
// Shared types and defaults for the effect chain sequencer and its helpers.
// Holds the FSM state encoding and the default per-slot WAIT budget.
package effect_chain_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_DISPATCH = 2'd1,
      ST_WAIT     = 2'd2,
      ST_OUT      = 2'd3
   } seq_state_t;

   localparam int DEFAULT_TIMEOUT_CYCLES = 1023;

endpackage

// File: rtl/effect_chain_sequencer_timer.sv
// WAIT-state watchdog: cleared on grant, counts while waiting, flags the limit.
// The count saturates at the limit so a stalled FSM cannot wrap it.
module effect_timeout_timer
   import effect_chain_sequencer_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic incr,
   output logic expired
);

   localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] LIMIT = TMR_W'(TIMEOUT_CYCLES);

   logic [TMR_W-1:0] tmr;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         tmr <= '0;
      end else if (incr && !expired) begin
         tmr <= tmr + TMR_W'(1);
      end
   end

   assign expired = (tmr == LIMIT);

endmodule

// File: rtl/effect_chain_sequencer.sv
// Initiator of the my_turn/cs/done handshake: walks one sample through the
// enabled effect slots in index order and emits the result as a single pulse.
module effect_chain_sequencer
   import effect_chain_sequencer_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int NUM_EFFECTS    = 4,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                sample_valid,
   input  logic signed [DATA_WIDTH-1:0]        sample_in,
   input  logic [NUM_EFFECTS-1:0]              effect_enable,
   output logic [NUM_EFFECTS-1:0]              effect_cs,
   output logic [NUM_EFFECTS-1:0]              my_turn,
   output logic signed [DATA_WIDTH-1:0]        effect_data_in,
   input  logic [NUM_EFFECTS-1:0]              effect_done,
   input  logic [NUM_EFFECTS*DATA_WIDTH-1:0]   effect_data_out,
   output logic signed [DATA_WIDTH-1:0]        sample_out,
   output logic                                sample_out_valid,
   output logic                                busy,
   output logic                                overrun,
   output logic                                timeout
);

   localparam int IDX_W = (NUM_EFFECTS > 1) ? $clog2(NUM_EFFECTS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_EFFECTS - 1);

   seq_state_t                   state, state_next;
   logic [IDX_W-1:0]             idx, idx_next;
   logic signed [DATA_WIDTH-1:0] acc, acc_next;
   logic signed [DATA_WIDTH-1:0] slot_data;
   logic [NUM_EFFECTS-1:0]       en, en_next;
   logic [NUM_EFFECTS-1:0]       turn_next;
   logic                         tmr_clear, tmr_incr, tmr_expired;
   logic                         overrun_set, timeout_set;

   effect_timeout_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (tmr_clear),
      .incr    (tmr_incr),
      .expired (tmr_expired)
   );

   always_comb begin
      state_next  = state;
      idx_next    = idx;
      acc_next    = acc;
      en_next     = en;
      turn_next   = my_turn;
      tmr_clear   = 1'b0;
      tmr_incr    = 1'b0;
      timeout_set = 1'b0;
      overrun_set = sample_valid && (state != ST_IDLE);
      slot_data   = effect_data_out[int'(idx)*DATA_WIDTH +: DATA_WIDTH];

      case (state)
         ST_IDLE: begin
            if (sample_valid) begin
               acc_next   = sample_in;
               en_next    = effect_enable;
               idx_next   = '0;
               state_next = ST_DISPATCH;
            end
         end

         ST_DISPATCH: begin
            if (en[idx]) begin
               turn_next      = '0;
               turn_next[idx] = 1'b1;
               tmr_clear      = 1'b1;
               state_next     = ST_WAIT;
            end else if (idx == LAST_IDX) begin
               state_next = ST_OUT;
            end else begin
               idx_next = idx + IDX_W'(1);
            end
         end

         // done has priority over the watchdog; a timed-out slot leaves acc untouched
         ST_WAIT: begin
            if (effect_done[idx] || tmr_expired) begin
               turn_next = '0;
               if (effect_done[idx]) begin
                  acc_next = slot_data;
               end else begin
                  timeout_set = 1'b1;
               end
               if (idx == LAST_IDX) begin
                  state_next = ST_OUT;
               end else begin
                  idx_next   = idx + IDX_W'(1);
                  state_next = ST_DISPATCH;
               end
            end else begin
               tmr_incr = 1'b1;
            end
         end

         ST_OUT: begin
            state_next = ST_IDLE;
         end

         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // sample_out/sample_out_valid are loaded on entry to OUT so they are valid during OUT
   always_ff @(posedge clk) begin
      if (rst) begin
         state            <= ST_IDLE;
         idx              <= '0;
         acc              <= '0;
         en               <= '0;
         my_turn          <= '0;
         sample_out       <= '0;
         sample_out_valid <= 1'b0;
         overrun          <= 1'b0;
         timeout          <= 1'b0;
      end else begin
         state            <= state_next;
         idx              <= idx_next;
         acc              <= acc_next;
         en               <= en_next;
         my_turn          <= turn_next;
         sample_out_valid <= (state_next == ST_OUT);
         if (state_next == ST_OUT) begin
            sample_out <= acc_next;
         end
         if (overrun_set) begin
            overrun <= 1'b1;
         end
         if (timeout_set) begin
            timeout <= 1'b1;
         end
      end
   end

   assign effect_data_in = acc;
   assign effect_cs      = en;
   assign busy           = (state != ST_IDLE);

endmodule

// File: doc/effect_chain_sequencer.md
# effect_chain_sequencer

Initiator side of the `my_turn`/`cs`/`done` effect handshake. It accepts one audio sample per `sample_valid` pulse and passes it through up to `NUM_EFFECTS` effect slots in index order. For each enabled slot it grants `my_turn`, waits for `done`, and captures that slot's output as the next slot's input. It sits between the codec receive path and the codec transmit path, and is the sole driver of every effect's `my_turn`, `cs` and `data_in`.

## Interface
- `DATA_WIDTH`, 16, sample width (signed two's complement).
- `NUM_EFFECTS`, 4, number of effect slots; slot 0 is processed first.
- `TIMEOUT_CYCLES`, 1023, maximum WAIT cycles per slot before abort.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `sample_valid`  in  1  one-cycle pulse, new input sample.
- `sample_in`  in  DATA_WIDTH  input sample, valid with `sample_valid`.
- `effect_enable`  in  NUM_EFFECTS  per-slot enable from the control panel.
- `effect_cs`  out  NUM_EFFECTS  per-slot `cs`, enables latched at sample accept.
- `my_turn`  out  NUM_EFFECTS  one-hot (or zero) grant to slot i.
- `effect_data_in`  out  DATA_WIDTH  shared data bus to all slots.
- `effect_done`  in  NUM_EFFECTS  per-slot `done`.
- `effect_data_out`  in  NUM_EFFECTS*DATA_WIDTH  slot i output at bits [i*DATA_WIDTH +: DATA_WIDTH]; valid while `effect_done[i]`=1.
- `sample_out`  out  DATA_WIDTH  processed sample.
- `sample_out_valid`  out  1  one-cycle pulse, `sample_out` valid.
- `busy`  out  1  high whenever state is not IDLE.
- `overrun`  out  1  sticky: a sample arrived while busy.
- `timeout`  out  1  sticky: a slot timed out.

## Operation
- States: IDLE, DISPATCH, WAIT, OUT. Index `idx`; accumulator `acc`; WAIT timer `tmr`, width clog2(TIMEOUT_CYCLES+1).
- IDLE: on `sample_valid`, set `acc`<=`sample_in`, latch `en`<=`effect_enable`, set `idx`<=0, then go to DISPATCH.
- DISPATCH:
  - If `en[idx]`: `my_turn[idx]`<=1, `tmr`<=0, go to WAIT.
  - Else skip the slot: if `idx`==N-1 go to OUT, otherwise `idx`++ and stay in DISPATCH.
- WAIT, evaluated in this priority order:
  1. `effect_done[idx]`=1: `acc`<=slot output, `my_turn`<=0, then advance (`idx`==N-1 goes to OUT, otherwise `idx`++ and go to DISPATCH).
  2. `tmr`==TIMEOUT_CYCLES: `my_turn`<=0, `timeout`<=1, `acc` unchanged (slot is bypassed), advance as above.
  3. Otherwise `tmr`++.
- OUT: `sample_out`=`acc`, `sample_out_valid`=1 for exactly this one cycle, then go to IDLE.
- `effect_data_in` = `acc`, a registered value held stable throughout WAIT.
- `effect_cs` = `en`; it is constant for the whole sample, so mid-sample changes to `effect_enable` have no effect.
- `my_turn` is registered and is dropped in the cycle after `done` is seen. A single-cycle responder is in its DONE state while `my_turn` is still high and is back in PASSIVE once `my_turn` is low, so it is never re-triggered.
- `effect_done[j]` for j≠`idx`, and any `done` outside WAIT, is ignored.
- A `sample_valid` in any state other than IDLE (including OUT) drops that sample and sets `overrun`<=1.
- `overrun` and `timeout` are cleared only by `rst`.
- No arithmetic is performed on samples; all data paths are pass-through registers of DATA_WIDTH.

## Timing
- Reset values: state IDLE; `my_turn`, `effect_cs`, `effect_data_in`, `sample_out`, `sample_out_valid`, `overrun`, `timeout` all 0; `busy` 0.
- Reset mid-operation: all `my_turn` are 0 from the cycle after `rst` is sampled, and the sample in flight is discarded.
- Cycle costs, with `sample_valid` sampled in IDLE at cycle k:
  - Enabled slot whose `done` arrives d cycles after it first sees `my_turn`: 2+d cycles (DISPATCH, then d+1 WAIT cycles).
  - Disabled slot: 1 cycle.
  - OUT: 1 cycle.
- N=4, all enabled, d=1: `sample_out_valid` at k+13.
- All disabled: `sample_out_valid` at k+5.
- Timeout slot: 2+TIMEOUT_CYCLES cycles.
- Minimum sample spacing without overrun is one cycle more than the chain latency.

## Structure
- A shared package holds the state enum (IDLE/DISPATCH/WAIT/OUT) and the default TIMEOUT_CYCLES constant.
- One sub-module, `effect_timeout_timer`, implements the clear/increment/expired counter used in WAIT.
- The FSM, `acc`, `en` and the output registers live in the top module.

## Test plan
- Four 1-cycle responders, each adding 0x0100, all enabled; `sample_in`=0x0010 → `sample_out`=0x0410 with `sample_out_valid` at k+13; `my_turn` is one-hot and each grant is high exactly 2 cycles.
- `effect_enable`=4'b0101, same responders; `sample_in`=0x1000 → `sample_out`=0x1200 at k+9; `my_turn[1]` and `my_turn[3]` never assert; `effect_cs`=4'b0101.
- Slot 2 never asserts `done`, TIMEOUT_CYCLES=8, all slots enabled; `sample_in`=0 → slot 2 bypassed, `sample_out`=0x0300, `timeout`=1 and stays 1 until `rst`.
- Second `sample_valid` 3 cycles after the first → second sample dropped, `overrun`=1, first sample's result unchanged.
- Slot 1 asserts `done` 5 cycles after `my_turn`; slot 3 asserts a spurious `done` during slot 1's WAIT → spurious `done` ignored, latency grows by 4 cycles, output correct.
- `rst` asserted while in WAIT on slot 2 → all outputs 0 the next cycle, IDLE, a new sample processes normally.
